// File: rtl/idct8_scatter_mac.sv
// 8-point inverse DCT row engine: each serial coefficient X[k] is scattered into eight
// sample accumulators through one shared signed multiplier, then rounded samples drain out.
`timescale 1ns/1ps
module idct8_scatter_mac #(
  parameter int IN_W  = 8,
  parameter int ACC_W = 20,
  parameter int OUT_W = 9,
  parameter int SHIFT = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [IN_W-1:0]  coef_in,
  input  logic                    coef_valid,
  output logic                    coef_ready,
  output logic signed [OUT_W-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last
);

  typedef enum logic [1:0] {IDLE, MAC, DRAIN} state_t;

  localparam logic signed [ACC_W-1:0] RND  = ACC_W'(2 ** (SHIFT - 1));
  localparam logic signed [ACC_W-1:0] MAXV = ACC_W'(2 ** (OUT_W - 1) - 1);
  localparam logic signed [ACC_W-1:0] MINV = ACC_W'(-(2 ** (OUT_W - 1)));

  state_t                  state_q;
  logic [2:0]              k_q, n_q;
  logic signed [IN_W-1:0]  coef_q;
  logic signed [ACC_W-1:0] acc_q [8];
  logic                    coef_ready_q, out_valid_q, out_last_q;
  logic signed [OUT_W-1:0] out_data_q;

  // W[k][n] = 32*cos((2n+1)k*pi/16) for k>0; the phase folds mod 32 onto a 16-entry cosine table.
  function automatic logic signed [6:0] rom_w(input logic [2:0] k, input logic [2:0] n);
    logic [4:0]        m;
    logic [4:0]        f;
    logic signed [6:0] w;
    m = {1'b0, n, 1'b1} * {2'b0, k};
    f = (m > 5'd16) ? 5'd0 - m : m;
    case (f)
      5'd1:    w = 7'sd31;
      5'd2:    w = 7'sd30;
      5'd3:    w = 7'sd27;
      5'd4:    w = 7'sd23;
      5'd5:    w = 7'sd18;
      5'd6:    w = 7'sd12;
      5'd7:    w = 7'sd6;
      5'd9:    w = -7'sd6;
      5'd10:   w = -7'sd12;
      5'd11:   w = -7'sd18;
      5'd12:   w = -7'sd23;
      5'd13:   w = -7'sd27;
      5'd14:   w = -7'sd30;
      5'd15:   w = -7'sd31;
      default: w = 7'sd0;
    endcase
    if (k == 3'd0) w = 7'sd23;
    return w;
  endfunction

  function automatic logic signed [OUT_W-1:0] round_sat(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] r;
    r = (a + RND) >>> SHIFT;
    if (r > MAXV) return MAXV[OUT_W-1:0];
    if (r < MINV) return MINV[OUT_W-1:0];
    return r[OUT_W-1:0];
  endfunction

  logic signed [6:0]         w_d;
  logic signed [IN_W+6:0]    prod_d;
  logic signed [ACC_W-1:0]   prod_ext_d, acc_base_d, sum_d;

  always_comb begin
    w_d        = rom_w(k_q, n_q);
    prod_d     = coef_q * w_d;
    prod_ext_d = {{(ACC_W-IN_W-7){prod_d[IN_W+6]}}, prod_d};
    acc_base_d = (k_q == 3'd0) ? '0 : acc_q[n_q];
    sum_d      = acc_base_d + prod_ext_d;
  end

  // Datapath storage needs no reset: k==0 overwrites every accumulator.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && coef_ready_q && coef_valid) coef_q <= coef_in;
    if (state_q == MAC) acc_q[n_q] <= sum_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      k_q          <= 3'd0;
      n_q          <= 3'd0;
      coef_ready_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      out_data_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (coef_ready_q && coef_valid) begin
            n_q          <= 3'd0;
            coef_ready_q <= 1'b0;
            state_q      <= MAC;
          end else begin
            coef_ready_q <= 1'b1;
          end
        end
        MAC: begin
          n_q <= n_q + 3'd1;
          if (n_q == 3'd7) begin
            if (k_q == 3'd7) begin
              // acc[0] is already final; acc[7] is being written this cycle.
              k_q         <= 3'd0;
              state_q     <= DRAIN;
              out_valid_q <= 1'b1;
              out_last_q  <= 1'b0;
              out_data_q  <= round_sat(acc_q[0]);
            end else begin
              k_q          <= k_q + 3'd1;
              coef_ready_q <= 1'b1;
              state_q      <= IDLE;
            end
          end
        end
        DRAIN: begin
          if (out_ready) begin
            if (n_q == 3'd7) begin
              n_q          <= 3'd0;
              out_valid_q  <= 1'b0;
              out_last_q   <= 1'b0;
              coef_ready_q <= 1'b1;
              state_q      <= IDLE;
            end else begin
              n_q        <= n_q + 3'd1;
              out_data_q <= round_sat(acc_q[n_q + 3'd1]);
              out_last_q <= (n_q == 3'd6);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign coef_ready = coef_ready_q;
  assign out_valid  = out_valid_q;
  assign out_last   = out_last_q;
  assign out_data   = out_data_q;

endmodule

// File: tb/tb_idct8_scatter_mac.sv
// Directed bench for idct8_scatter_mac: DC, AC1, saturation, backpressure, mid-row reset
// and back-to-back rows, with hand-computed expected samples.
`timescale 1ns/1ps
module tb_idct8_scatter_mac;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic signed [7:0] coef_in = '0;
  logic              coef_valid = 1'b0;
  logic              coef_ready;
  logic signed [8:0] out_data;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic              out_last;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int exp_ac[8] = '{31, 27, 18, 6, -6, -18, -27, -31};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  idct8_scatter_mac dut (
    .clk        (clk),
    .rst        (rst),
    .coef_in    (coef_in),
    .coef_valid (coef_valid),
    .coef_ready (coef_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last)
  );

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Presents one coefficient and returns #1 after the accepting edge.
  task automatic send(input int x, input string tag);
    int w = 0;
    coef_in    = 8'(x);
    coef_valid = 1'b1;
    while (coef_ready !== 1'b1 && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    chk({tag, "_coef_ready"}, coef_ready, 1);
    @(posedge clk); #1;
    coef_valid = 1'b0;
  endtask

  task automatic recv(input int exp, input bit last_exp, input bit chk_data, input string tag);
    int w = 0;
    out_ready = 1'b1;
    while (out_valid !== 1'b1 && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    chk({tag, "_valid"}, out_valid, 1);
    if (chk_data) chk({tag, "_data"}, out_data, exp);
    chk({tag, "_last"}, out_last, last_exp);
    chk({tag, "_crdy_low"}, coef_ready, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    int w;
    int prev;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_coef_ready", coef_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_data", out_data, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_rst", coef_ready, 1);

    // DC row
    for (int k = 0; k < 8; k++) send((k == 0) ? 64 : 0, "t1");
    for (int n = 0; n < 8; n++) recv(23, n == 7, 1'b1, "t1");

    // AC1 row, including the tie-rounding negatives
    for (int k = 0; k < 8; k++) send((k == 1) ? 64 : 0, "t2");
    for (int n = 0; n < 8; n++) recv(exp_ac[n], n == 7, 1'b1, "t2");

    // Saturation: x[0] raw 337 -> 255, x[1] = 127*-46 -> -91; then raw -340 -> -256, x[1] 92
    for (int k = 0; k < 8; k++) send(127, "t3p");
    recv(255, 1'b0, 1'b1, "t3p_x0");
    recv(-91, 1'b0, 1'b1, "t3p_x1");
    for (int n = 2; n < 8; n++) recv(0, n == 7, 1'b0, "t3p");
    for (int k = 0; k < 8; k++) send(-128, "t3n");
    recv(-256, 1'b0, 1'b1, "t3n_x0");
    recv(92, 1'b0, 1'b1, "t3n_x1");
    for (int n = 2; n < 8; n++) recv(0, n == 7, 1'b0, "t3n");

    // Backpressure held for three cycles at n=3
    for (int k = 0; k < 8; k++) send((k == 1) ? 64 : 0, "t4");
    for (int n = 0; n < 3; n++) recv(exp_ac[n], 1'b0, 1'b1, "t4");
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("t4_hold_valid", out_valid, 1);
      chk("t4_hold_data", out_data, 6);
      chk("t4_hold_last", out_last, 0);
      chk("t4_hold_crdy", coef_ready, 0);
    end
    for (int n = 3; n < 8; n++) recv(exp_ac[n], n == 7, 1'b1, "t4");
    chk("t4_ready_after_last", coef_ready, 1);

    // Reset while the k=3 coefficient is in MAC
    send(100, "t5");
    send(-50, "t5");
    send(20, "t5");
    send(7, "t5");
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("t5_rst_coef_ready", coef_ready, 0);
    chk("t5_rst_out_valid", out_valid, 0);
    chk("t5_rst_out_last", out_last, 0);
    chk("t5_rst_out_data", out_data, 0);
    @(posedge clk); #1;
    chk("t5_ready_after_rst", coef_ready, 1);
    for (int k = 0; k < 8; k++) send((k == 1) ? 64 : 0, "t5");
    for (int n = 0; n < 8; n++) recv(exp_ac[n], n == 7, 1'b1, "t5");

    // Back-to-back rows with coef_valid held high
    coef_valid = 1'b1;
    prev = 0;
    for (int k = 0; k < 16; k++) begin
      coef_in = (k == 0 || k == 9) ? 8'sd64 : 8'sd0;
      w = 0;
      while (coef_ready !== 1'b1 && w < 100) begin
        @(posedge clk); #1;
        w++;
      end
      chk("t6_coef_ready", coef_ready, 1);
      if (k == 8) chk("t6_row2_no_gap", w, 0);
      else if (k != 0) chk("t6_accept_interval", cyc - prev, 9);
      prev = cyc;
      @(posedge clk); #1;
      if (k == 7) begin
        coef_in = 8'sd0;
        for (int n = 0; n < 8; n++) recv(23, n == 7, 1'b1, "t6_row1");
      end
    end
    coef_valid = 1'b0;
    for (int n = 0; n < 8; n++) recv(exp_ac[n], n == 7, 1'b1, "t6_row2");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
